// File: rtl/dmem_io_pkg.sv
// Shared constants and helpers for the memory-mapped I/O data memory:
// I/O register byte offsets, 7-segment hex decode and the reset display pattern.
package dmem_io_pkg;

  localparam logic [3:0] DISP_OFS = 4'h0;
  localparam logic [3:0] SW_OFS   = 4'h2;
  localparam logic [3:0] EDGE_OFS = 4'h4;
  localparam logic [3:0] CYC_OFS  = 4'h6;

  // Active-low segments, bit order gfedcba; this is the "0" glyph.
  localparam logic [6:0] DISP_RESET = 7'b1000000;

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-FF synchroniser, stability counter and accepted value.
// rise pulses for one cycle on the clock edge where the accepted value goes 0->1.
module sw_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_stable,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise     = 1'b0;
    // Count only while the synchronised input disagrees with the accepted value.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      rise     = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sw_stable = stable_q;

endmodule

// File: rtl/dmemory_io_n.sv
// Data memory with an I/O page (DISP, SW, EDGE, CYC) for the 16-bit MIPS core.
// Define DMEM_CYCLE_COUNTER_EN to build the free-running CYC counter.
module dmemory_io_n
  import dmem_io_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               DEPTH      = 128,
  parameter int               NUM_SW     = 2,
  parameter int               DEB_CYCLES = 16,
  parameter logic [WIDTH-1:0] IO_BASE    = 16'hFFF0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  addr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              write,
  input  logic              read,
  input  logic [NUM_SW-1:0] io_sw,
  output logic [WIDTH-1:0]  rdata,
  output logic [6:0]        io_display
);

  localparam int AW = $clog2(DEPTH);

  logic          io_sel;
  logic [3:0]    io_ofs;
  logic [AW-1:0] ram_idx;
  logic          unused_addr0;

  assign io_sel       = (addr[WIDTH-1:4] == IO_BASE[WIDTH-1:4]);
  assign io_ofs       = {addr[3:1], 1'b0};
  assign ram_idx      = addr[AW:1];
  assign unused_addr0 = addr[0];

  logic [WIDTH-1:0] ram_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (write && !io_sel) begin
      ram_mem[ram_idx] <= wdata;
    end
  end

  logic [NUM_SW-1:0] sw_vec;
  logic [NUM_SW-1:0] sw_rise;

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock    (clock),
      .reset    (reset),
      .sw_raw   (io_sw[gi]),
      .sw_stable(sw_vec[gi]),
      .rise     (sw_rise[gi])
    );
  end

  logic [3:0]        disp_q, disp_d;
  logic [6:0]        display_q, display_d;
  logic [NUM_SW-1:0] edge_q, edge_d;
  logic              edge_clr;
  logic [WIDTH-1:0]  cyc_val;

  always_comb begin
    disp_d = disp_q;
    if (write && io_sel && (io_ofs == DISP_OFS)) begin
      disp_d = wdata[3:0];
    end
    display_d = hex7seg(disp_d);
    // A rise landing on the clearing edge wins, so no edge is ever lost.
    edge_clr = read && io_sel && (io_ofs == EDGE_OFS);
    edge_d   = (edge_clr ? '0 : edge_q) | sw_rise;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_q    <= 4'h0;
      display_q <= DISP_RESET;
      edge_q    <= '0;
    end else begin
      disp_q    <= disp_d;
      display_q <= display_d;
      edge_q    <= edge_d;
    end
  end

  assign io_display = display_q;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [WIDTH-1:0] cyc_q, cyc_d;

  always_comb begin
    if (write && io_sel && (io_ofs == CYC_OFS)) begin
      cyc_d = '0;
    end else begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  always_comb begin
    rdata = '0;
    if (read) begin
      if (io_sel) begin
        case (io_ofs)
          DISP_OFS: rdata[3:0]        = disp_q;
          SW_OFS:   rdata[NUM_SW-1:0] = sw_vec;
          EDGE_OFS: rdata[NUM_SW-1:0] = edge_q;
          CYC_OFS:  rdata             = cyc_val;
          default:  rdata             = '0;
        endcase
      end else begin
        rdata = ram_mem[ram_idx];
      end
    end
  end

endmodule

// File: tb/tb_dmemory_io_n.sv
// Directed bench for dmemory_io_n: RAM/DISP vector table, then hand-written
// debounce, EDGE read-clear, reset and CYC sequences.
module tb_dmemory_io_n;

  logic        clock;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        write;
  logic        read;
  logic [1:0]  io_sw;
  logic [15:0] rdata;
  logic [6:0]  io_display;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DMEM_CYCLE_COUNTER_EN
  localparam bit CYC_EN = 1'b1;
`else
  localparam bit CYC_EN = 1'b0;
`endif

  dmemory_io_n dut (
    .clock     (clock),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .write     (write),
    .read      (read),
    .io_sw     (io_sw),
    .rdata     (rdata),
    .io_display(io_display)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic [6:0]  exp_disp;
  } vec_t;

  vec_t vecs[22];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [15:0] exp);
    write = 1'b0;
    read  = 1'b1;
    addr  = a;
    #1;
    check(name, rdata, exp);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'hFFF0, 16'h0000, 16'h0000, 7'h40};
    vecs[1]  = '{1'b0, 1'b1, 16'hFFF2, 16'h0000, 16'h0000, 7'h40};
    vecs[2]  = '{1'b0, 1'b1, 16'hFFF4, 16'h0000, 16'h0000, 7'h40};
    vecs[3]  = '{1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 7'h40};
    vecs[4]  = '{1'b1, 1'b0, 16'h0110, 16'hABCD, 16'h0000, 7'h40};
    vecs[5]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hABCD, 7'h40};
    vecs[6]  = '{1'b1, 1'b0, 16'h00F0, 16'h4321, 16'h0000, 7'h40};
    vecs[7]  = '{1'b1, 1'b0, 16'hFFF0, 16'h000A, 16'h0000, 7'h40};
    vecs[8]  = '{1'b0, 1'b1, 16'hFFF0, 16'h0000, 16'h000A, 7'h08};
    vecs[9]  = '{1'b0, 1'b1, 16'h00F0, 16'h0000, 16'h4321, 7'h08};
    vecs[10] = '{1'b1, 1'b0, 16'h0020, 16'h5555, 16'h0000, 7'h08};
    vecs[11] = '{1'b1, 1'b1, 16'h0020, 16'hAAAA, 16'h5555, 7'h08};
    vecs[12] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'hAAAA, 7'h08};
    vecs[13] = '{1'b1, 1'b0, 16'hFFF8, 16'h1234, 16'h0000, 7'h08};
    vecs[14] = '{1'b0, 1'b1, 16'hFFF8, 16'h0000, 16'h0000, 7'h08};
    vecs[15] = '{1'b0, 1'b1, 16'hFFFE, 16'h0000, 16'h0000, 7'h08};
    vecs[16] = '{1'b1, 1'b0, 16'hFFF2, 16'hFFFF, 16'h0000, 7'h08};
    vecs[17] = '{1'b0, 1'b1, 16'hFFF2, 16'h0000, 16'h0000, 7'h08};
    vecs[18] = '{1'b1, 1'b1, 16'hFFF0, 16'h0007, 16'h000A, 7'h08};
    vecs[19] = '{1'b0, 1'b1, 16'hFFF0, 16'h0000, 16'h0007, 7'h78};
    vecs[20] = '{1'b1, 1'b0, 16'hFFF0, 16'h000C, 16'h0000, 7'h78};
    vecs[21] = '{1'b0, 1'b0, 16'hFFF0, 16'h0000, 16'h0000, 7'h46};

    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    write = 1'b0;
    read  = 1'b0;
    io_sw = 2'b00;
    step();
    step();
    reset = 1'b0;

    // Vector table: rdata/io_display are checked before the edge that applies the write.
    for (int i = 0; i < 22; i++) begin
      write = vecs[i].wr;
      read  = vecs[i].rd;
      addr  = vecs[i].addr;
      wdata = vecs[i].wdata;
      #1;
      $display("vec %0d: wr=%b rd=%b addr=%h wdata=%h rdata=%h disp=%b",
               i, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, rdata, io_display);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_disp", i), {9'b0, io_display}, {9'b0, vecs[i].exp_disp});
      step();
    end
    write = 1'b0;
    read  = 1'b0;

    // Switch 0 rise: accepted exactly on the 18th edge after the raw change.
    io_sw = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      step();
      rd_check($sformatf("sw_edge%0d", k), 16'hFFF2, (k >= 18) ? 16'h0001 : 16'h0000);
      $display("sw latency edge %0d: rdata=%h", k, rdata);
    end
    rd_check("edge_first_read", 16'hFFF4, 16'h0001);
    step();
    rd_check("edge_after_clear", 16'hFFF4, 16'h0000);
    step();
    read = 1'b0;

    // 5-cycle glitch on switch 1 must be rejected.
    io_sw[1] = 1'b1;
    repeat (5) step();
    io_sw[1] = 1'b0;
    repeat (25) step();
    rd_check("glitch_sw", 16'hFFF2, 16'h0001);
    rd_check("glitch_edge", 16'hFFF4, 16'h0000);
    $display("glitch: sw/edge checked");
    read = 1'b0;

    // Bring switch 0 back to 0 (falling edges never set a flag).
    io_sw = 2'b00;
    repeat (22) step();
    rd_check("fall_sw", 16'hFFF2, 16'h0000);
    read = 1'b0;

    // Switch 0 rises at edge 18, switch 1 at edge 21; read-clear lands on edge 21.
    io_sw[0] = 1'b1;
    repeat (3) step();
    io_sw[1] = 1'b1;
    repeat (17) step();
    rd_check("clr_race_before", 16'hFFF4, 16'h0001);
    step();
    rd_check("clr_race_after", 16'hFFF4, 16'h0002);
    step();
    rd_check("clr_race_final", 16'hFFF4, 16'h0000);
    rd_check("clr_race_sw", 16'hFFF2, 16'h0003);
    $display("edge read-clear race: checked");
    read = 1'b0;

    // Reset mid-debounce, switches held high across reset release.
    io_sw = 2'b00;
    repeat (5) step();
    #3;
    reset = 1'b1;
    io_sw = 2'b11;
    rd_check("rst_sw", 16'hFFF2, 16'h0000);
    rd_check("rst_edge", 16'hFFF4, 16'h0000);
    check("rst_disp", {9'b0, io_display}, {9'b0, 7'b1000000});
    rd_check("rst_ram_kept", 16'h0010, 16'hABCD);
    read = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 10) begin
        rd_check("cyc_at_10", 16'hFFF6, CYC_EN ? 16'd10 : 16'd0);
      end else begin
        rd_check($sformatf("rst_sw_edge%0d", k), 16'hFFF2, (k >= 18) ? 16'h0003 : 16'h0000);
      end
      $display("post-reset edge %0d: addr=%h rdata=%h", k, addr, rdata);
    end
    rd_check("rst_edge_flags", 16'hFFF4, 16'h0003);
    step();
    read = 1'b0;

    // CYC write loads 0 on the write edge, then resumes counting.
    write = 1'b1;
    addr  = 16'hFFF6;
    wdata = 16'h1234;
    step();
    rd_check("cyc_after_write", 16'hFFF6, 16'h0000);
    step();
    rd_check("cyc_plus1", 16'hFFF6, CYC_EN ? 16'h0001 : 16'h0000);
    $display("cyc write: checked");
    read = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
